// File: rtl/usb_camera_pattern_gen_if.sv
// Video-frame fetch port: UVC core (master) pulls pattern bytes from the generator (slave).
// Also carries the per-frame pattern select and frame status back to the core/board controls.
interface usb_camera_pattern_gen_if;
  logic [1:0]  mode;
  logic        vf_sof;
  logic        vf_req;
  logic [7:0]  vf_byte;
  logic [15:0] frame_cnt;
  logic [1:0]  frame_mode;
  logic        frame_done;
  logic        overrun;

  modport master (
    output mode, vf_sof, vf_req,
    input  vf_byte, frame_cnt, frame_mode, frame_done, overrun
  );

  modport slave (
    input  mode, vf_sof, vf_req,
    output vf_byte, frame_cnt, frame_mode, frame_done, overrun
  );
endinterface

// File: rtl/usb_camera_pattern_gen.sv
// Test-pattern byte source (RAMP/BARS/CHECKER/SCROLL) in MONO or YUY2 order.
// vf_byte is registered: byte 0 one cycle after vf_sof, next byte one cycle after each vf_req.
module usb_camera_pattern_gen #(
  parameter              FRAME_TYPE = "MONO",
  parameter logic [13:0] FRAME_W    = 14'd252,
  parameter logic [13:0] FRAME_H    = 14'd120,
  parameter int          CHK_LOG2   = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  usb_camera_pattern_gen_if.slave  vf_if
);
  localparam bit YUY2 = (FRAME_TYPE == "YUY2");
  localparam int BXW  = YUY2 ? 15 : 14;
  localparam int BPL  = YUY2 ? 2 * int'(FRAME_W) : int'(FRAME_W);
  localparam logic [BXW-1:0] BX_LAST  = BXW'(BPL - 1);
  localparam logic [13:0]    Y_LAST   = FRAME_H - 14'd1;
  localparam logic [13:0]    BAR_LAST = (FRAME_W >> 3) - 14'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
  state_e state_q, state_d;

  logic [BXW-1:0] bx_q, bx_d;
  logic [13:0]    y_q, y_d, pc_q, pc_d, row_q, row_d, frow_q, frow_d;
  logic [2:0]     bi_q, bi_d;
  logic [7:0]     n_q, n_d, seed_q, seed_d, byte_q, byte_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [1:0]     fmode_q, fmode_d;
  logic           done_q, done_d, ovr_q, ovr_d;
  logic           load;

  // row_q tracks (frame_cnt mod 256) mod FRAME_H so the scroll row never needs a modulo.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    y_d     = y_q;
    pc_d    = pc_q;
    bi_d    = bi_q;
    n_d     = n_q;
    row_d   = row_q;
    frow_d  = frow_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    fmode_d = fmode_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
    load    = 1'b0;
    if (vf_if.vf_sof) begin
      state_d = ST_RUN;
      fmode_d = vf_if.mode;
      seed_d  = cnt_q[7:0];
      cnt_d   = cnt_q + 16'd1;
      frow_d  = row_q;
      row_d   = (cnt_q[7:0] == 8'hFF || row_q == Y_LAST) ? 14'd0 : row_q + 14'd1;
      bx_d    = '0;
      y_d     = '0;
      pc_d    = '0;
      bi_d    = '0;
      n_d     = '0;
      ovr_d   = 1'b0;
      load    = 1'b1;
    end else if (vf_if.vf_req) begin
      case (state_q)
        ST_RUN: begin
          if (bx_q == BX_LAST && y_q == Y_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
            n_d  = n_q + 8'd1;
            if (bx_q == BX_LAST) begin
              bx_d = '0;
              y_d  = y_q + 14'd1;
              pc_d = '0;
              bi_d = '0;
            end else begin
              bx_d = bx_q + BXW'(1);
              // pixel column steps on every byte in MONO, after the odd byte in YUY2
              if ((!YUY2 || bx_q[0]) && bi_q != 3'd7) begin
                if (pc_q == BAR_LAST) begin
                  bi_d = bi_q + 3'd1;
                  pc_d = '0;
                end else begin
                  pc_d = pc_q + 14'd1;
                end
              end
            end
          end
        end
        ST_DONE: ovr_d = 1'b1;
        default: ;
      endcase
    end
  end

  logic [1:0]  pm;
  logic [7:0]  ps, bar_y, bar_u, bar_v, pat;
  logic [13:0] pr, px, cx;
  logic        chroma, is_v;

  always_comb begin
    pm     = vf_if.vf_sof ? vf_if.mode : fmode_q;
    ps     = vf_if.vf_sof ? cnt_q[7:0] : seed_q;
    pr     = vf_if.vf_sof ? row_q : frow_q;
    px     = YUY2 ? 14'(bx_d >> 1) : 14'(bx_d);
    cx     = px ^ y_d;
    chroma = YUY2 && bx_d[0];
    is_v   = bx_d[1];
    case (bi_d)
      3'd0:    {bar_y, bar_u, bar_v} = {8'd235, 8'd128, 8'd128};
      3'd1:    {bar_y, bar_u, bar_v} = {8'd210, 8'd16,  8'd146};
      3'd2:    {bar_y, bar_u, bar_v} = {8'd170, 8'd166, 8'd16};
      3'd3:    {bar_y, bar_u, bar_v} = {8'd145, 8'd54,  8'd34};
      3'd4:    {bar_y, bar_u, bar_v} = {8'd106, 8'd202, 8'd222};
      3'd5:    {bar_y, bar_u, bar_v} = {8'd81,  8'd90,  8'd240};
      3'd6:    {bar_y, bar_u, bar_v} = {8'd41,  8'd240, 8'd110};
      default: {bar_y, bar_u, bar_v} = {8'd16,  8'd128, 8'd128};
    endcase
    case (pm)
      2'd0:    pat = ps + n_d;
      2'd1:    pat = chroma ? (is_v ? bar_v : bar_u) : bar_y;
      2'd2:    pat = chroma ? 8'd128 : (cx[CHK_LOG2] ? 8'd235 : 8'd16);
      default: pat = chroma ? 8'd128 : ((y_d == pr) ? 8'd235 : 8'd16);
    endcase
    byte_d = load ? pat : byte_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      bx_q    <= '0;
      y_q     <= '0;
      pc_q    <= '0;
      bi_q    <= '0;
      n_q     <= '0;
      row_q   <= '0;
      frow_q  <= '0;
      seed_q  <= '0;
      cnt_q   <= '0;
      fmode_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      y_q     <= y_d;
      pc_q    <= pc_d;
      bi_q    <= bi_d;
      n_q     <= n_d;
      row_q   <= row_d;
      frow_q  <= frow_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      fmode_q <= fmode_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign vf_if.vf_byte    = byte_q;
  assign vf_if.frame_cnt  = cnt_q;
  assign vf_if.frame_mode = fmode_q;
  assign vf_if.frame_done = done_q;
  assign vf_if.overrun    = ovr_q;
endmodule

// File: tb/tb_usb_camera_pattern_gen.sv
// Drives three differently-configured generators with one shared stimulus stream and
// compares every output against a frame-level reference model after each clock.
module tb_usb_camera_pattern_gen;
  logic       clk = 1'b0;
  logic       rstn, sof, req;
  logic [1:0] mode;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  localparam int CW [3] = '{8, 16, 8};
  localparam int CH [3] = '{2, 2, 4};
  localparam int CY [3] = '{0, 1, 0};
  localparam int CC [3] = '{3, 3, 1};
  localparam int BAR_Y [8] = '{235, 210, 170, 145, 106, 81, 41, 16};
  localparam int BAR_U [8] = '{128, 16, 166, 54, 202, 90, 240, 128};
  localparam int BAR_V [8] = '{128, 146, 16, 34, 222, 240, 110, 128};

  usb_camera_pattern_gen_if vif0 ();
  usb_camera_pattern_gen_if vif1 ();
  usb_camera_pattern_gen_if vif2 ();

  assign vif0.vf_sof = sof;  assign vif0.vf_req = req;  assign vif0.mode = mode;
  assign vif1.vf_sof = sof;  assign vif1.vf_req = req;  assign vif1.mode = mode;
  assign vif2.vf_sof = sof;  assign vif2.vf_req = req;  assign vif2.mode = mode;

  usb_camera_pattern_gen #(.FRAME_TYPE("MONO"), .FRAME_W(14'd8), .FRAME_H(14'd2), .CHK_LOG2(3))
    dut0 (.clk(clk), .rstn(rstn), .vf_if(vif0));
  usb_camera_pattern_gen #(.FRAME_TYPE("YUY2"), .FRAME_W(14'd16), .FRAME_H(14'd2), .CHK_LOG2(3))
    dut1 (.clk(clk), .rstn(rstn), .vf_if(vif1));
  usb_camera_pattern_gen #(.FRAME_TYPE("MONO"), .FRAME_W(14'd8), .FRAME_H(14'd4), .CHK_LOG2(1))
    dut2 (.clk(clk), .rstn(rstn), .vf_if(vif2));

  int o_byte [3], o_cnt [3], o_mode [3], o_done [3], o_ovr [3];
  always_comb begin
    o_byte[0] = int'(vif0.vf_byte); o_cnt[0] = int'(vif0.frame_cnt); o_mode[0] = int'(vif0.frame_mode);
    o_done[0] = int'(vif0.frame_done); o_ovr[0] = int'(vif0.overrun);
    o_byte[1] = int'(vif1.vf_byte); o_cnt[1] = int'(vif1.frame_cnt); o_mode[1] = int'(vif1.frame_mode);
    o_done[1] = int'(vif1.frame_done); o_ovr[1] = int'(vif1.overrun);
    o_byte[2] = int'(vif2.vf_byte); o_cnt[2] = int'(vif2.frame_cnt); o_mode[2] = int'(vif2.frame_mode);
    o_done[2] = int'(vif2.frame_done); o_ovr[2] = int'(vif2.overrun);
  end

  // reference model state, one entry per instance
  int m_armed [3], m_cmpl [3], m_ovr [3], m_done [3], m_cnt [3];
  int m_mode [3], m_seed [3], m_k [3], m_byte [3];

  function automatic int n_bytes(int i);
    return CW[i] * (CY[i] ? 2 : 1) * CH[i];
  endfunction

  function automatic int ref_byte(int i, int md, int seed, int k);
    int bpl, bx, y, px, bi;
    bit chroma, isv;
    bpl    = CW[i] * (CY[i] ? 2 : 1);
    bx     = k % bpl;
    y      = k / bpl;
    px     = CY[i] ? bx / 2 : bx;
    chroma = CY[i] && (bx % 2 == 1);
    isv    = (bx % 4 == 3);
    bi     = px / (CW[i] / 8);
    if (bi > 7) bi = 7;
    case (md)
      0: return (seed + k) % 256;
      1: return chroma ? (isv ? BAR_V[bi] : BAR_U[bi]) : BAR_Y[bi];
      2: return chroma ? 128 : ((((px ^ y) >> CC[i]) & 1) ? 235 : 16);
      default: return chroma ? 128 : ((y == seed % CH[i]) ? 235 : 16);
    endcase
  endfunction

  task automatic chk_eq(string tag, int obs, int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(int i, bit s, bit r, int m, bit rn);
    if (!rn) begin
      m_armed[i] = 0; m_cmpl[i] = 0; m_ovr[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
      m_mode[i] = 0; m_seed[i] = 0; m_k[i] = 0; m_byte[i] = 0;
    end else begin
      m_done[i] = 0;
      if (s) begin
        m_mode[i]  = m;
        m_seed[i]  = m_cnt[i] % 256;
        m_cnt[i]   = (m_cnt[i] + 1) % 65536;
        m_k[i]     = 0;
        m_cmpl[i]  = 0;
        m_ovr[i]   = 0;
        m_armed[i] = 1;
        m_byte[i]  = ref_byte(i, m, m_seed[i], 0);
      end else if (r && m_armed[i] != 0) begin
        if (m_cmpl[i] != 0) m_ovr[i] = 1;
        else if (m_k[i] == n_bytes(i) - 1) begin
          m_cmpl[i] = 1;
          m_done[i] = 1;
        end else begin
          m_k[i]++;
          m_byte[i] = ref_byte(i, m_mode[i], m_seed[i], m_k[i]);
        end
      end
    end
  endtask

  task automatic cyc(bit s, bit r, int m, bit rn);
    @(negedge clk);
    sof  = s;
    req  = r;
    mode = 2'(m);
    rstn = rn;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, s, r, m, rn);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("i%0d vf_byte", i), o_byte[i], m_byte[i]);
      chk_eq($sformatf("i%0d frame_cnt", i), o_cnt[i], m_cnt[i]);
      chk_eq($sformatf("i%0d frame_mode", i), o_mode[i], m_mode[i]);
      chk_eq($sformatf("i%0d frame_done", i), o_done[i], m_done[i]);
      chk_eq($sformatf("i%0d overrun", i), o_ovr[i], m_ovr[i]);
    end
  endtask

  initial begin
    rstn = 1'b0; sof = 1'b0; req = 1'b0; mode = 2'd0;
    repeat (3) cyc(1, 1, 1, 0);
    repeat (3) cyc(0, 1, 0, 1);

    // each pattern from a fresh reset; SCROLL runs five frames so the white row walks
    for (int m = 0; m < 4; m++) begin
      cyc(0, 0, 0, 0);
      for (int f = 0; f < (m == 3 ? 5 : 2); f++) begin
        cyc(1, 0, m, 1);
        repeat (70) cyc(0, 1, m, 1);
      end
    end

    cyc(1, 1, 2, 1);
    repeat (4) cyc(0, 1, 2, 1);
    cyc(1, 1, 1, 1);
    repeat (3) cyc(0, 0, 1, 1);

    cyc(1, 0, 0, 1);
    repeat (5) cyc(0, 1, 0, 1);
    repeat (10) cyc(0, 1, 1, 1);
    cyc(1, 0, 1, 1);
    repeat (10) cyc(0, 1, 1, 1);

    cyc(1, 0, 2, 1);
    repeat (5) cyc(0, 1, 2, 1);
    cyc(0, 1, 2, 0);
    repeat (5) cyc(0, 1, 2, 1);
    cyc(1, 0, 2, 1);
    repeat (40) cyc(0, 1, 3, 1);

    for (int t = 0; t < 4000; t++) begin
      cyc($urandom_range(99) == 0, $urandom_range(3) != 0,
          int'($urandom_range(3)), $urandom_range(599) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/usb_camera_pattern_gen.md
# usb_camera_pattern_gen

Parametrised test-pattern source for the `usb_camera_top` video-frame fetch interface (`vf_sof` / `vf_req` / `vf_byte`). It replaces the fixed incrementing-byte generator in the FPGA top level. It provides four run-time selectable patterns in MONO or YUY2 byte order, a frame counter, end-of-frame and overrun status. It sits in the `clk` (60 MHz) domain between the UVC core and board-level controls such as switches or debug registers.

## Interface
- `FRAME_TYPE`, "MONO": "MONO" gives 1 byte/pixel; "YUY2" gives 2 bytes/pixel in order Y0 U Y1 V. Must match `usb_camera_top`.
- `FRAME_W`, 14'd252: width in pixels. Even, and ≥ 8.
- `FRAME_H`, 14'd120: height in lines. Even.
- `CHK_LOG2`, 3: checkerboard square size is 2^CHK_LOG2 pixels. Range 0..6.
- `clk` input 1: core clock. All logic runs on its rising edge.
- `rstn` input 1: reset, synchronous, active-low.
- `mode` input 2: pattern select. 0 = RAMP, 1 = BARS, 2 = CHECKER, 3 = SCROLL. Sampled only at `vf_sof`.
- `vf_sof` input 1: start-of-frame pulse from the UVC core.
- `vf_req` input 1: consumer has taken the current `vf_byte` and requests the next one.
- `vf_byte` output 8: current byte, registered.
- `frame_cnt` output 16: number of `vf_sof` pulses seen since reset. Wraps modulo 2^16.
- `frame_mode` output 2: pattern latched for the current frame.
- `frame_done` output 1: one-cycle pulse when the last byte of a frame is consumed.
- `overrun` output 1: sticky flag, set by a `vf_req` after the frame is complete. Cleared by `vf_sof`.

## Operation
- Bytes per line: BPL = FRAME_W for MONO, 2·FRAME_W for YUY2. Bytes per frame: N = BPL·FRAME_H.
- Internal state:
  - byte column `bx` (0..BPL−1), line `y` (0..FRAME_H−1), linear index `n` (8-bit, wraps).
  - pixel column `px`: equals `bx` for MONO, `bx>>1` for YUY2.
  - bar index `bi` (0..7), tracked incrementally. No dividers are allowed.
  - `armed` flag, 0 at reset and set by the first `vf_sof`.
- On `vf_sof`:
  - latch `mode` into `frame_mode`;
  - latch seed = `frame_cnt[7:0]` (the value before increment);
  - increment `frame_cnt`;
  - zero `bx`, `y`, `n` and `bi`;
  - clear `overrun`;
  - set `armed`;
  - load `vf_byte` with byte 0 of the new frame.
- On `vf_req` with `armed` and frame incomplete: advance `bx`. At `bx` = BPL−1, wrap `bx` to 0 and increment `y`. Load `vf_byte` with the byte at the new position.
- On `vf_req` consuming byte N−1: pulse `frame_done` and mark the frame complete. `vf_byte` is held.
- On `vf_req` while complete: set `overrun`. Counters and `vf_byte` are unchanged.
- `vf_req` while not `armed` is ignored.
- `vf_sof` together with `vf_req` in the same cycle: `vf_sof` wins and the request is dropped.
- Pattern bytes (Y = luma byte; U/V = chroma bytes, YUY2 only, where `bx` mod 4 = 1 is U and 3 is V; chroma uses the even pixel of the pair):
  - RAMP: byte = (seed + n) mod 256 for every byte, in both frame types. For MONO this is identical to the legacy generator.
  - BARS: `bi` = min(px / (FRAME_W/8), 7). The remainder pixels belong to bar 7. (Y,U,V) per bar 0..7:
    - bar 0: (235,128,128)
    - bar 1: (210,16,146)
    - bar 2: (170,166,16)
    - bar 3: (145,54,34)
    - bar 4: (106,202,222)
    - bar 5: (81,90,240)
    - bar 6: (41,240,110)
    - bar 7: (16,128,128)
  - CHECKER: Y = 235 if ((px ^ y) >> CHK_LOG2) & 1, else 16. U = V = 128.
  - SCROLL: Y = 235 on line `y` == seed mod FRAME_H, else 16. U = V = 128. Line position is computed with a compare against a per-frame registered row, not a modulo operator.
- A `mode` change mid-frame has no effect until the next `vf_sof`.

## Timing
- Reset (`rstn` = 0 at a clock edge) forces all of the following on that edge, regardless of `vf_sof` / `vf_req`:
  - `vf_byte` = 0, `frame_cnt` = 0, `frame_mode` = 0;
  - `frame_done` = 0, `overrun` = 0;
  - all counters 0, `armed` = 0.
- Latency: `vf_byte` shows byte 0 one cycle after `vf_sof`. It shows byte k+1 one cycle after the `vf_req` that consumed byte k.
- Back-to-back `vf_req` on every cycle is supported, at one byte per cycle.
- `frame_done` is asserted in the cycle after the final `vf_req`.
- `overrun` rises in the cycle after the offending `vf_req`.
- Reset asserted mid-frame: the frame is abandoned and the next frame requires a fresh `vf_sof`.
- Width rules: `bx`/`y` are 14 bits (15 bits for `bx` in YUY2). `n` and the seed sum are 8-bit and wrap. `frame_cnt` is 16-bit and wraps.

## Test plan
- MONO RAMP, W=8, H=2:
  - Stimulus: two frames, `vf_req` on every cycle.
  - Frame 0 bytes: 0x00..0x0F. Frame 1 bytes: 0x01..0x10.
  - `frame_done` pulses once per frame. `frame_cnt` reaches 2.
- YUY2 BARS, W=16, H=2:
  - Line 0 bytes 0..3 = 235,128,235,128.
  - Bytes 4..7 = 210,16,210,146.
  - Bytes 28..31 = 16,128,16,128.
  - Line 1 repeats line 0.
- MONO CHECKER, CHK_LOG2=1, W=8, H=4:
  - Line 0 = 16,16,235,235,16,16,235,235.
  - Line 2 is the inverse of line 0.
- SCROLL, MONO, W=8, H=4, run 5 frames:
  - The white line sits at rows 0,1,2,3,0 in frames 0..4.
- Collisions and overrun:
  - `vf_sof` with `vf_req` in the same cycle: byte 0 is presented, not byte 1.
  - N+3 requests in one frame: `overrun` = 1 and `vf_byte` is held. The next `vf_sof` clears `overrun`.
- Mode and reset:
  - `mode` changed 0→1 mid-frame: the pattern stays RAMP until the next `vf_sof`, then becomes BARS.
  - `rstn` pulsed mid-frame: all outputs are 0, and `vf_req` is ignored until `vf_sof`.
